puf_challenge_sequencer: RTL and testbench
==========================================

Name: puf_challenge_sequencer

Overview:
Sequences one arbiter-PUF evaluation per request. It latches a challenge, drives the shared launch edge into both race paths, waits for the race to settle, and samples the PUF response through a synchronizer. It repeats the race VOTE_N times and returns a majority-voted response bit plus a stability flag. It sits between the AXI-side register logic and the 64-stage arbiter PUF core, and is the only block that drives the core's challenge and launch inputs.

Parameters:
CHAL_W, 64, challenge width; must equal the PUF stage count.
SETTLE_CYC, 8, cycles spent in each of ARM (launch low) and FIRE (launch high); must be >= 3 to cover synchronizer latency.
VOTE_N, 7, races per request; odd, >= 1.
ONES_W, $clog2(VOTE_N+1), width of the ones counter (derived; do not override).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  challenge request valid
req_ready  out  1  sequencer can accept a request
req_chal  in  CHAL_W  challenge for the request
puf_chal  out  CHAL_W  challenge to PUF select inputs
puf_launch  out  1  launch edge; drives both PUF race inputs (a and b)
puf_resp  in  1  raw PUF output (arbiter flop q), asynchronous to clk
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumed
rsp_bit  out  1  majority response
rsp_ones  out  ONES_W  number of races that returned 1
rsp_stable  out  1  all VOTE_N races agreed
busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0 except req_ready=1; puf_chal=0; counters and synchronizer flops 0.
- Synchronizer: puf_resp passes through 2 flops (resp_s) before any use.
- IDLE: req_ready=1.
  - On req_valid&&req_ready: latch req_chal into puf_chal; clear the ones and trial counters; go to ARM.
- ARM: puf_launch=0 for SETTLE_CYC cycles, so both race paths discharge; then go to FIRE.
- FIRE: puf_launch=1 for SETTLE_CYC cycles; then go to SAMPLE.
- SAMPLE: one cycle, puf_launch stays 1.
  - ones += resp_s; trial += 1.
  - If the new trial count == VOTE_N, go to DONE; else go to ARM.
- DONE: puf_launch=0; rsp_valid=1.
  - rsp_bit = (ones > VOTE_N/2).
  - rsp_stable = (ones==0 || ones==VOTE_N).
  - rsp_ones = ones.
  - On rsp_valid&&rsp_ready: go to IDLE. rsp_valid drops the next cycle. No request is accepted in the handshake cycle; req_ready rises the cycle after.
- Latency: rsp_valid is first seen high after N*(2*SETTLE_CYC+1) clk edges following the accept edge (119 with defaults).
- puf_chal changes only on an accept edge or reset. It is stable for every race and holds after DONE.
- req_valid outside IDLE is ignored (req_ready=0); req_chal is not sampled.
- rsp outputs are stable while rsp_valid=1 && rsp_ready=0. Backpressure is unbounded, and puf_launch stays 0 throughout.
- resp_s is used only in SAMPLE; toggles of puf_resp during ARM/FIRE have no effect.
- rst_n asserted mid-operation: puf_launch, rsp_valid and busy go 0 immediately (asynchronously). The in-flight request is discarded with no partial result.
- Counters never wrap: trial ≤ VOTE_N and ones ≤ VOTE_N by construction. ONES_W holds VOTE_N.

Test Plan:
(Bench uses SETTLE_CYC=4, VOTE_N=3 and a behavioural PUF model; per-request latency = 27 cycles.)
1. Challenge 64'hDEAD_BEEF_0123_4567, model returns 1 every race -> rsp_valid at edge 27 after accept; rsp_bit=1, rsp_ones=3, rsp_stable=1; puf_chal constant throughout.
2. Model returns 1,0,1 on successive races -> rsp_bit=1, rsp_ones=2, rsp_stable=0. Then model returns 0,0,1 -> rsp_bit=0, rsp_ones=1, rsp_stable=0.
3. Launch waveform check -> each race shows puf_launch low 4 cycles then high 5 cycles (FIRE+SAMPLE), repeated 3 times, then low; busy high for all 27 cycles.
4. rsp_ready held 0 for 10 cycles in DONE -> rsp_* unchanged, req_ready=0, puf_launch=0. A req_valid pulse with a new challenge during this time leaves puf_chal unchanged. After rsp_ready=1, req_ready rises 1 cycle after the handshake.
5. Model toggles puf_resp every cycle during ARM/FIRE but settles to 0 three cycles before SAMPLE -> rsp_ones=0, rsp_stable=1.
6. rst_n pulsed low in the 2nd race's FIRE -> puf_launch=0 and busy=0 without waiting for clk; after release, a new request completes in exactly 27 cycles with counts from zero.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: runs VOTE_N launch/settle/sample races per request
// and returns a majority-voted response bit with a stability flag.
module puf_challenge_sequencer #(
  parameter int unsigned CHAL_W     = 64,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned VOTE_N     = 7,
  parameter int unsigned ONES_W     = $clog2(VOTE_N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CHAL_W-1:0] req_chal,
  output logic [CHAL_W-1:0] puf_chal,
  output logic              puf_launch,
  input  logic              puf_resp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_bit,
  output logic [ONES_W-1:0] rsp_ones,
  output logic              rsp_stable,
  output logic              busy
);

  localparam int unsigned CntW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CntW-1:0]   CntLast = CntW'(SETTLE_CYC - 1);
  localparam logic [ONES_W-1:0] VoteN   = ONES_W'(VOTE_N);
  localparam logic [ONES_W-1:0] HalfN   = ONES_W'(VOTE_N / 2);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StFire,
    StSample,
    StDone
  } state_e;

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic [ONES_W-1:0]   r_trial, w_trial_d;
  logic [ONES_W-1:0]   r_ones, w_ones_d;
  logic [CHAL_W-1:0]   r_chal, w_chal_d;
  logic [1:0]          r_sync;
  logic                w_resp_s;
  logic [ONES_W-1:0]   w_trial_inc;

  // puf_resp is asynchronous to clk; only the second flop is ever consumed.
  assign w_resp_s    = r_sync[1];
  assign w_trial_inc = r_trial + ONES_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_trial <= '0;
      r_ones  <= '0;
      r_chal  <= '0;
      r_sync  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_trial <= w_trial_d;
      r_ones  <= w_ones_d;
      r_chal  <= w_chal_d;
      r_sync  <= {r_sync[0], puf_resp};
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_trial_d = r_trial;
    w_ones_d  = r_ones;
    w_chal_d  = r_chal;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_chal_d  = req_chal;
          w_ones_d  = '0;
          w_trial_d = '0;
          w_cnt_d   = '0;
          w_state_d = StArm;
        end
      end
      StArm: begin
        if (r_cnt == CntLast) begin
          w_cnt_d   = '0;
          w_state_d = StFire;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StFire: begin
        if (r_cnt == CntLast) begin
          w_cnt_d   = '0;
          w_state_d = StSample;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StSample: begin
        w_ones_d  = r_ones + ONES_W'(w_resp_s);
        w_trial_d = w_trial_inc;
        w_cnt_d   = '0;
        w_state_d = (w_trial_inc == VoteN) ? StDone : StArm;
      end
      StDone: begin
        if (rsp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Launch stays high through SAMPLE so the arbiter output is captured on a settled race.
  assign req_ready  = (r_state == StIdle);
  assign busy       = (r_state != StIdle);
  assign puf_launch = (r_state == StFire) || (r_state == StSample);
  assign puf_chal   = r_chal;
  assign rsp_valid  = (r_state == StDone);
  assign rsp_ones   = rsp_valid ? r_ones : '0;
  assign rsp_bit    = rsp_valid && (r_ones > HalfN);
  assign rsp_stable = rsp_valid && ((r_ones == '0) || (r_ones == VoteN));

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Randomized bench for puf_challenge_sequencer with a behavioural PUF and a
// race-timeline reference model (SETTLE_CYC=4, VOTE_N=3).
module tb_puf_challenge_sequencer;

  localparam int unsigned ChalW   = 64;
  localparam int unsigned Settle  = 4;
  localparam int unsigned VoteN   = 3;
  localparam int unsigned OnesW   = $clog2(VoteN + 1);
  localparam int unsigned RaceCyc = 2 * Settle + 1;
  localparam int unsigned Lat     = VoteN * RaceCyc;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [ChalW-1:0] req_chal;
  logic [ChalW-1:0] puf_chal;
  logic             puf_launch;
  logic             puf_resp;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_bit;
  logic [OnesW-1:0] rsp_ones;
  logic             rsp_stable;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  puf_challenge_sequencer #(
    .CHAL_W    (ChalW),
    .SETTLE_CYC(Settle),
    .VOTE_N    (VoteN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_chal  (req_chal),
    .puf_chal  (puf_chal),
    .puf_launch(puf_launch),
    .puf_resp  (puf_resp),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_bit   (rsp_bit),
    .rsp_ones  (rsp_ones),
    .rsp_stable(rsp_stable),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request. vals[r] is the PUF's settled answer for race r; in toggle mode
  // the PUF chatters during ARM/FIRE and settles to 0 three cycles before sampling.
  // abort_j >= 0 pulses reset at that cycle offset from the accept edge.
  task automatic run_request(input logic [63:0] chal, input logic [2:0] vals, input bit toggle,
                             input int bp, input int abort_j, input logic [63:0] intruder);
    int exp_ones;
    bit exp_bit;
    bit exp_stable;
    check_eq("idle_req_ready", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_chal  = chal;
    tick();
    req_valid = 1'b0;
    req_chal  = {$urandom, $urandom};
    for (int j = 0; j < int'(Lat); j++) begin
      int r = j / int'(RaceCyc);
      int p = j % int'(RaceCyc);
      if (j == abort_j) begin
        check_eq("pre_rst_launch", {63'd0, puf_launch}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_launch", {63'd0, puf_launch}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_puf_chal", puf_chal, 64'd0);
        #3;
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_ready", {63'd0, req_ready}, 64'd1);
        return;
      end
      check_eq("race_launch", {63'd0, puf_launch}, {63'd0, p >= int'(Settle)});
      check_eq("race_busy", {63'd0, busy}, 64'd1);
      check_eq("race_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check_eq("race_req_ready", {63'd0, req_ready}, 64'd0);
      check_eq("race_puf_chal", puf_chal, chal);
      if (toggle) puf_resp = (p < int'(RaceCyc) - 4) ? ~puf_resp : 1'b0;
      else        puf_resp = vals[r];
      tick();
    end
    exp_ones = 0;
    for (int r = 0; r < int'(VoteN); r++) exp_ones += toggle ? 0 : int'(vals[r]);
    exp_bit    = (2 * exp_ones > int'(VoteN));
    exp_stable = (exp_ones == 0) || (exp_ones == int'(VoteN));
    check_eq("done_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check_eq("done_rsp_ones", 64'(rsp_ones), 64'(exp_ones));
    check_eq("done_rsp_bit", {63'd0, rsp_bit}, {63'd0, exp_bit});
    check_eq("done_rsp_stable", {63'd0, rsp_stable}, {63'd0, exp_stable});
    check_eq("done_launch", {63'd0, puf_launch}, 64'd0);
    for (int k = 0; k < bp; k++) begin
      check_eq("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check_eq("bp_rsp_ones", 64'(rsp_ones), 64'(exp_ones));
      check_eq("bp_rsp_bit", {63'd0, rsp_bit}, {63'd0, exp_bit});
      check_eq("bp_req_ready", {63'd0, req_ready}, 64'd0);
      check_eq("bp_launch", {63'd0, puf_launch}, 64'd0);
      check_eq("bp_puf_chal", puf_chal, chal);
      req_valid = (k == bp / 2);
      req_chal  = intruder;
      puf_resp  = 1'($urandom);
      tick();
      req_valid = 1'b0;
    end
    check_eq("bp_end_puf_chal", puf_chal, chal);
    rsp_ready = 1'b1;
    check_eq("hs_req_ready", {63'd0, req_ready}, 64'd0);
    tick();
    rsp_ready = 1'b0;
    check_eq("post_hs_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("post_hs_req_ready", {63'd0, req_ready}, 64'd1);
    check_eq("post_hs_busy", {63'd0, busy}, 64'd0);
    check_eq("post_hs_puf_chal", puf_chal, chal);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_chal  = '0;
    puf_resp  = 1'b0;
    rsp_ready = 1'b0;
    #12;
    check_eq("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_launch", {63'd0, puf_launch}, 64'd0);
    check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("rst_rsp_ones", 64'(rsp_ones), 64'd0);
    check_eq("rst_puf_chal", puf_chal, 64'd0);
    #11;
    rst_n = 1'b1;
    tick();

    run_request(64'hDEAD_BEEF_0123_4567, 3'b111, 1'b0, 0, -1, 64'd0);
    run_request({$urandom, $urandom}, 3'b101, 1'b0, 2, -1, 64'd0);
    run_request({$urandom, $urandom}, 3'b100, 1'b0, 0, -1, 64'd0);
    run_request(64'h0123_4567_89AB_CDEF, 3'b111, 1'b0, 10, -1, 64'hFFFF_0000_FFFF_0000);
    run_request({$urandom, $urandom}, 3'b111, 1'b1, 1, -1, 64'd0);
    run_request({$urandom, $urandom}, 3'b011, 1'b0, 0, int'(RaceCyc + Settle + 1), 64'd0);
    run_request({$urandom, $urandom}, 3'b010, 1'b0, 1, -1, 64'd0);

    for (int i = 0; i < 20; i++) begin
      run_request({$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 5)), -1, {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
